ebus_diag_master: RTL and testbench

- Front-end side of the EBUS diagnostic interface; the initiator that the EBOX boards (CON, CTL, ...) respond to.
- Accepts one command at a time from the console/DTE logic and drives the diagnostic select code, diagnostic strobe and write data onto the EBUS.
- For diagnostic read functions it samples the EBUS data lines and returns them.
- Provides a built-in KL start sequence: CLR RUN, SET RUN, CONTINUE.

---
 rtl/ebus_diag_master.sv | 172 +++++++++++++++++
 tb/tb_ebus_diag_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_diag_master.sv
// rtl/ebus_diag_master.sv - EBUS diagnostic initiator: CTL/READ/WRITE cycles plus the KL start sequence.
module ebus_diag_master #(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 2,
    parameter int READ_SETTLE = 3,
    parameter int HOLD_CYC    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [0:6]  cmd_func,
    input  logic [0:35] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [0:35] rsp_data,
    output logic [0:6]  ebus_ds,
    output logic        ebus_diag_strobe,
    output logic        ebus_diag_read,
    output logic [0:35] ebus_data_out,
    output logic        ebus_data_oe,
    input  logic [0:35] ebus_data_in,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACTIVE, S_HOLD, S_RESP} state_t;

    localparam logic [1:0] OP_CTL   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_START = 2'd3;

    // Counters hold "cycles remaining minus one" so a phase ends when they reach zero.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] SETTLE_LD = 8'(READ_SETTLE - 1);
    localparam logic [7:0] HOLD_LD   = 8'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_t       r_state;
    logic [7:0]   r_cnt;
    logic [1:0]   r_op;
    logic [1:0]   r_idx;
    logic         r_cmd_ready;
    logic         r_rsp_valid;
    logic [0:35]  r_rsp_data;
    logic [0:6]   r_ds;
    logic         r_strobe;
    logic         r_read;
    logic [0:35]  r_data_out;
    logic         r_data_oe;
    logic         r_busy;

    logic w_accept;
    logic w_cnt_zero;
    logic w_act_done;
    logic w_hold_done;

    assign w_accept    = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
    assign w_cnt_zero  = (r_cnt == 8'd0);
    assign w_act_done  = (r_state == S_ACTIVE) && w_cnt_zero;
    // With no hold time the end-of-hold decision is taken on the last active cycle.
    assign w_hold_done = ((r_state == S_HOLD) && w_cnt_zero) || (w_act_done && (HOLD_CYC == 0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_op        <= OP_CTL;
            r_idx       <= 2'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ds        <= '0;
            r_strobe    <= 1'b0;
            r_read      <= 1'b0;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_op        <= cmd_op;
                        r_idx       <= 2'd0;
                        r_cnt       <= SETUP_LD;
                        r_state     <= S_SETUP;
                        r_ds        <= (cmd_op == OP_START) ? 7'o010 : cmd_func;
                        r_data_oe   <= (cmd_op == OP_WRITE);
                        r_data_out  <= (cmd_op == OP_WRITE) ? cmd_data : '0;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_ACTIVE;
                        if (r_op == OP_READ) begin
                            r_read <= 1'b1;
                            r_cnt  <= SETTLE_LD;
                        end else begin
                            r_strobe <= 1'b1;
                            r_cnt    <= STROBE_LD;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (w_cnt_zero) begin
                        r_strobe <= 1'b0;
                        r_read   <= 1'b0;
                        if (r_op == OP_READ) begin
                            r_rsp_data <= ebus_data_in;
                        end
                        r_state <= S_HOLD;
                        r_cnt   <= HOLD_LD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // End of a bus cycle: respond, chain the next START step, or release the bus.
            if (w_hold_done) begin
                if (r_op == OP_READ) begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_ds        <= '0;
                end else if ((r_op == OP_START) && (r_idx < 2'd2)) begin
                    r_idx   <= r_idx + 2'd1;
                    r_ds    <= 7'o011 + {5'b0, r_idx};
                    r_cnt   <= SETUP_LD;
                    r_state <= S_SETUP;
                end else begin
                    r_ds        <= '0;
                    r_data_oe   <= 1'b0;
                    r_data_out  <= '0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            end
        end
    end

    assign cmd_ready        = r_cmd_ready;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_data         = r_rsp_data;
    assign ebus_ds          = r_ds;
    assign ebus_diag_strobe = r_strobe;
    assign ebus_diag_read   = r_read;
    assign ebus_data_out    = r_data_out;
    assign ebus_data_oe     = r_data_oe;
    assign busy             = r_busy;

endmodule

// File: tb/tb_ebus_diag_master.sv
// tb/tb_ebus_diag_master.sv - scoreboard bench for ebus_diag_master (default and minimum-timing instances).
module tb_ebus_diag_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_op;
    logic [0:6]  cmd_func, ebus_ds;
    logic [0:35] cmd_data, rsp_data, ebus_data_out, ebus_data_in;
    logic        ebus_diag_strobe, ebus_diag_read, ebus_data_oe, busy;

    logic        s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready;
    logic [1:0]  s_cmd_op;
    logic [0:6]  s_cmd_func, s_ebus_ds;
    logic [0:35] s_cmd_data, s_rsp_data, s_ebus_data_out, s_ebus_data_in;
    logic        s_ebus_diag_strobe, s_ebus_diag_read, s_ebus_data_oe, s_busy;

    ebus_diag_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_func(cmd_func), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe), .ebus_diag_read(ebus_diag_read),
        .ebus_data_out(ebus_data_out), .ebus_data_oe(ebus_data_oe), .ebus_data_in(ebus_data_in),
        .busy(busy)
    );

    ebus_diag_master #(.SETUP_CYC(1), .STROBE_CYC(1), .READ_SETTLE(1), .HOLD_CYC(0)) dut_s (
        .clk(clk), .reset(reset),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_op(s_cmd_op),
        .cmd_func(s_cmd_func), .cmd_data(s_cmd_data),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .ebus_ds(s_ebus_ds), .ebus_diag_strobe(s_ebus_diag_strobe), .ebus_diag_read(s_ebus_diag_read),
        .ebus_data_out(s_ebus_data_out), .ebus_data_oe(s_ebus_data_oe), .ebus_data_in(s_ebus_data_in),
        .busy(s_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    typedef struct {
        logic [0:6]  ds;
        logic        oe;
        logic [0:35] d;
        int          width;
    } sexp_t;

    sexp_t       sq[$];
    logic [0:35] rq[$];

    function automatic sexp_t mk(input logic [0:6] ds, input logic oe, input logic [0:35] d, input int w);
        sexp_t e;
        e.ds = ds; e.oe = oe; e.d = d; e.width = w;
        return e;
    endfunction

    // Monitor: pops expected strobe pulses and read responses as the DUT presents them.
    logic       prev_st = 1'b0, prev_rd = 1'b0;
    logic [0:6] prev_ds = '0;
    int         wcnt = 0;
    sexp_t      cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_st = 1'b0;
            prev_rd = 1'b0;
            wcnt    = 0;
        end else begin
            if (ebus_diag_strobe && ebus_diag_read) begin
                n_tests++; n_fail++;
                $display("FAIL overlap: strobe and read both high");
            end
            if ((ebus_diag_strobe || ebus_diag_read) && (prev_st || prev_rd) && (ebus_ds !== prev_ds)) begin
                n_tests++; n_fail++;
                $display("FAIL ds_moved: got %0o expected %0o", ebus_ds, prev_ds);
            end
            if (ebus_diag_strobe && !prev_st) begin
                if (sq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_strobe: got ds %0o expected no strobe", ebus_ds);
                end else begin
                    cur = sq.pop_front();
                    chk("strobe_ds", 64'(ebus_ds), 64'(cur.ds));
                    chk("strobe_oe", 64'(ebus_data_oe), 64'(cur.oe));
                    chk("strobe_data", 64'(ebus_data_out), 64'(cur.d));
                end
                wcnt = 1;
            end else if (ebus_diag_strobe) begin
                wcnt++;
            end else if (prev_st) begin
                chk("strobe_width", 64'(wcnt), 64'(cur.width));
            end
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: got %0o expected no response", rsp_data);
                end else begin
                    chk("rsp_data", 64'(rsp_data), 64'(rq.pop_front()));
                end
            end
            prev_st = ebus_diag_strobe;
            prev_rd = ebus_diag_read;
            prev_ds = ebus_ds;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [0:6] f, input logic [0:35] d);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_tests++; n_fail++;
            $display("FAIL issue_timeout: got cmd_ready 0 expected 1");
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_func = f; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic s_issue(input logic [1:0] op, input logic [0:6] f);
        int t = 0;
        @(negedge clk);
        while (!s_cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_cmd_ready) begin
            n_tests++; n_fail++;
            $display("FAIL s_issue_timeout: got cmd_ready 0 expected 1");
        end
        s_cmd_valid = 1'b1; s_cmd_op = op; s_cmd_func = f;
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
    endtask

    localparam logic [0:35] RD_WORD = 36'o123456701234;
    localparam logic [0:35] WR_WORD = 36'o777000111222;

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_func = '0; cmd_data = '0;
        rsp_ready = 1'b0; ebus_data_in = '0;
        s_cmd_valid = 1'b0; s_cmd_op = 2'd0; s_cmd_func = '0; s_cmd_data = '0;
        s_rsp_ready = 1'b1; s_ebus_data_in = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {ebus_ds, ebus_diag_strobe, ebus_diag_read, ebus_data_oe, rsp_valid, busy, cmd_ready}, 64'd0);
        chk("reset_data", {ebus_data_out, 1'b0}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", {cmd_ready, busy}, {1'b1, 1'b0});

        // CTL 012
        sq.push_back(mk(7'o012, 1'b0, 36'd0, 2));
        issue(2'd0, 7'o012, 36'o777777777777);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("ctl_k%0d", k), {ebus_ds, ebus_diag_strobe, cmd_ready},
                {(k <= 5) ? 7'o012 : 7'o000, (k == 3 || k == 4), (k == 6)});
        end

        // READ 131 with a stalled consumer
        ebus_data_in = RD_WORD;
        rq.push_back(RD_WORD);
        issue(2'd1, 7'o131, 36'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("read_k%0d", k), {ebus_ds, ebus_diag_read, ebus_diag_strobe, rsp_valid},
                {(k <= 6) ? 7'o131 : 7'o000, (k >= 3 && k <= 5), 1'b0, (k == 7)});
        end
        ebus_data_in = 36'o0;
        for (int k = 8; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("rsp_hold_k%0d", k), {rsp_valid, rsp_data, busy}, {1'b1, RD_WORD, 1'b1});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("read_idle", {cmd_ready, rsp_valid, busy}, {1'b1, 1'b0, 1'b0});

        // WRITE 070
        sq.push_back(mk(7'o070, 1'b1, WR_WORD, 2));
        issue(2'd2, 7'o070, WR_WORD);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("write_k%0d", k), {ebus_data_oe, ebus_data_out, ebus_diag_strobe, ebus_ds},
                {(k <= 5), (k <= 5) ? WR_WORD : 36'd0, (k == 3 || k == 4), (k <= 5) ? 7'o070 : 7'o000});
        end

        // START sequence with an ignored mid-sequence command
        sq.push_back(mk(7'o010, 1'b0, 36'd0, 2));
        sq.push_back(mk(7'o011, 1'b0, 36'd0, 2));
        sq.push_back(mk(7'o012, 1'b0, 36'd0, 2));
        issue(2'd3, 7'o077, 36'o555);
        for (int k = 1; k <= 16; k++) begin
            int m;
            logic [0:6] eds;
            m = (k - 1) % 5 + 1;
            eds = (k <= 5) ? 7'o010 : (k <= 10) ? 7'o011 : (k <= 15) ? 7'o012 : 7'o000;
            @(negedge clk);
            chk($sformatf("start_k%0d", k), {ebus_ds, ebus_diag_strobe, busy, cmd_ready},
                {eds, (k <= 15) && (m == 3 || m == 4), (k <= 15), (k == 16)});
            if (k == 7) begin
                cmd_valid = 1'b1; cmd_op = 2'd0; cmd_func = 7'o055;
            end
            if (k == 8) cmd_valid = 1'b0;
        end

        // Reset during the ACTIVE phase of a READ
        ebus_data_in = 36'o111111111111;
        issue(2'd1, 7'o020, 36'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_read_active", 64'(ebus_diag_read), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ctl", {ebus_ds, ebus_diag_strobe, ebus_diag_read, ebus_data_oe, rsp_valid, busy, cmd_ready}, 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_data_out", 64'(ebus_data_out), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", {cmd_ready, busy}, {1'b1, 1'b0});
        repeat (12) @(posedge clk);
        #1;
        chk("rst_no_rsp", 64'(rsp_valid), 64'd0);

        // Minimum-timing instance
        s_issue(2'd0, 7'o044);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("s_ctl_k%0d", k), {s_ebus_ds, s_ebus_diag_strobe, s_cmd_ready},
                {(k <= 2) ? 7'o044 : 7'o000, (k == 2), (k == 3)});
        end
        s_ebus_data_in = 36'o765432107654;
        s_issue(2'd1, 7'o101);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("s_read_k%0d", k), {s_ebus_ds, s_ebus_diag_read, s_rsp_valid},
                {(k <= 2) ? 7'o101 : 7'o000, (k == 2), (k == 3)});
            if (k == 3) chk("s_rsp_data", 64'(s_rsp_data), 64'(36'o765432107654));
        end
        @(negedge clk);
        s_cmd_valid = 1'b1; s_cmd_op = 2'd0; s_cmd_func = 7'o061;
        @(posedge clk); #1;
        s_cmd_func = 7'o062;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("s_b2b_k%0d", k), {s_ebus_ds, s_cmd_ready},
                {(k <= 2) ? 7'o061 : 7'o000, (k == 3)});
        end
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        @(negedge clk);
        chk("s_b2b_second", {s_ebus_ds, s_cmd_ready}, {7'o062, 1'b0});
        repeat (4) @(posedge clk);
        #1;

        chk("strobe_queue_empty", 64'(sq.size()), 64'd0);
        chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
